// File: rtl/btn_debounce.sv
// Debounces one asynchronous push-button into a clean level plus one-cycle press/release strobes.
// Latency: DEBOUNCE_CYCLES+2 clk cycles from the first edge sampling a new raw level to the output change.
// Backpressure: none; strobes are fire-and-forget single-cycle pulses.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s;
    logic [CNT_W-1:0] cnt;
    state_t           state;

    // Two-flop synchronizer; only s is ever looked at by the state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s  <= 1'b0;
        end else begin
            s1 <= btn_raw;
            s  <= s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    btn_level <= 1'b0;
                    if (s) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state       <= PRESSED;
                        btn_level   <= 1'b1;
                        press_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    btn_level <= 1'b1;
                    if (!s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    // A bounce back to 1 returns to PRESSED without touching the level.
                    if (s) begin
                        state <= PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        state         <= IDLE;
                        btn_level     <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    btn_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=4: table-driven vectors plus hand-built bounce/reset sequences.
module tb_btn_debounce;

    logic clk = 1'b0;
    logic rst;
    logic btn_raw;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    btn_debounce #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic r;
        logic b;
        logic lvl;
        logic pr;
        logic rl;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic b, input logic lvl, input logic pr, input logic rl);
        vec_t v;
        v.r   = r;
        v.b   = b;
        v.lvl = lvl;
        v.pr  = pr;
        v.rl  = rl;
        vecs.push_back(v);
    endtask

    task automatic cmp(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d: got %0b want %0b", nm, cyc, act, exp);
        end
    endtask

    // Drive inputs, advance one edge, then sample outputs 1 time unit after it.
    task automatic step(input logic r, input logic b, input logic el, input logic ep, input logic er,
                        input string nm);
        rst     = r;
        btn_raw = b;
        @(posedge clk);
        #1;
        cyc++;
        cmp({nm, ".level"},   btn_level,     el);
        cmp({nm, ".press"},   press_pulse,   ep);
        cmp({nm, ".release"}, release_pulse, er);
    endtask

    logic [4:0] bpat;
    logic [2:0] rpat;

    initial begin
        rst     = 1'b1;
        btn_raw = 1'b1;

        // Reset held with the button pressed: everything stays low.
        for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Clean press: entry k is edge E_k after the raw rise; press on E6.
        for (int k = 0; k < 20; k++)
            add(1'b0, 1'b1, (k >= 6) ? 1'b1 : 1'b0, (k == 6) ? 1'b1 : 1'b0, 1'b0);
        // Clean release back to idle, release on E6.
        for (int k = 0; k < 10; k++)
            add(1'b0, 1'b0, (k < 6) ? 1'b1 : 1'b0, 1'b0, (k == 6) ? 1'b1 : 1'b0);
        // Three-cycle glitch: never accepted.
        for (int k = 0; k < 3; k++)  add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].r, vecs[i].b, vecs[i].lvl, vecs[i].pr, vecs[i].rl, "vec");

        // Press bounce 1,0,1,0,1 then held: last rise sampled at k=4, press at k=10.
        bpat = 5'b10101;
        for (int k = 0; k < 16; k++) begin
            logic b;
            b = (k < 5) ? bpat[4-k] : 1'b1;
            step(1'b0, b, (k >= 10) ? 1'b1 : 1'b0, (k == 10) ? 1'b1 : 1'b0, 1'b0, "pbounce");
        end

        // Release bounce 0,1,0 then held low: last fall sampled at k=2, release at k=8.
        rpat = 3'b010;
        for (int k = 0; k < 14; k++) begin
            logic b;
            b = (k < 3) ? rpat[2-k] : 1'b0;
            step(1'b0, b, (k < 8) ? 1'b1 : 1'b0, 1'b0, (k == 8) ? 1'b1 : 1'b0, "rbounce");
        end

        // Reach PRESSED, then reset for two cycles with the button still held.
        for (int k = 0; k < 8; k++)
            step(1'b0, 1'b1, (k >= 6) ? 1'b1 : 1'b0, (k == 6) ? 1'b1 : 1'b0, 1'b0, "prehold");
        for (int k = 0; k < 2; k++)
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "midrst");
        // After reset the full sequence repeats: fresh press at k=6.
        for (int k = 0; k < 12; k++)
            step(1'b0, 1'b1, (k >= 6) ? 1'b1 : 1'b0, (k == 6) ? 1'b1 : 1'b0, 1'b0, "postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Conditions one raw push-button input into a clean, debounced level and single-cycle press/release strobes. It sits directly upstream of the 8-bit switch-capture register. Its `press_pulse` drives that register's load input, so each physical press captures the switches exactly once regardless of contact bounce. The block has one clock domain; the raw button is asynchronous to it.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable cycles required to accept a new button level (10 ms at 100 MHz). Must be ≥ 1.
- `CNT_W`, 20: debounce counter width. Must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.

Ports:
- `clk`, input, 1: system clock; all logic on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `btn_raw`, input, 1: raw, bouncy, asynchronous button.
- `btn_level`, output, 1: debounced button level.
- `press_pulse`, output, 1: high for exactly one cycle when a press is accepted.
- `release_pulse`, output, 1: high for exactly one cycle when a release is accepted.

## Operation
- **Synchronizer:** two-flop chain `btn_raw` → `s1` → `s`. The FSM uses only `s`.
- **State machine:** four states, IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. There is one shared counter `cnt`.
  - **IDLE** (`btn_level`=0): if `s`=1, go to PRESS_WAIT with `cnt`←0.
  - **PRESS_WAIT** (`btn_level`=0):
    - If `s`=0, return to IDLE (glitch rejected, no pulse).
    - Else if `cnt`==DEBOUNCE_CYCLES−1, go to PRESSED and assert `press_pulse`.
    - Else `cnt`←`cnt`+1.
  - **PRESSED** (`btn_level`=1): if `s`=0, go to RELEASE_WAIT with `cnt`←0.
  - **RELEASE_WAIT** (`btn_level`=1):
    - If `s`=1, return to PRESSED (bounce rejected, no pulse).
    - Else if `cnt`==DEBOUNCE_CYCLES−1, go to IDLE and assert `release_pulse`.
    - Else `cnt`←`cnt`+1.
- **Output registers:** all outputs are registered. `btn_level` is 1 exactly while the state is PRESSED or RELEASE_WAIT.
- **Pulse exclusivity:** `press_pulse` and `release_pulse` are never high in the same cycle. Neither is high two cycles in a row.
- **Counter range:** `cnt` never exceeds DEBOUNCE_CYCLES−1 and never wraps.
- **Reset:** `rst` dominates all other inputs.
  - On any edge with `rst`=1: `s1`, `s`, `cnt` ←0; state ←IDLE; `btn_level`, `press_pulse`, `release_pulse` ←0.
  - Reset mid-press with the button still held: after reset deasserts, the full synchronize-and-debounce sequence repeats and a fresh `press_pulse` is produced.

## Timing
- **Press latency:** let E0 be the first edge sampling `btn_raw`=1, with the raw input stable from then on.
  - E1: `s`=1.
  - E2: PRESS_WAIT, `cnt`=0.
  - E(N+2): PRESSED, where N = DEBOUNCE_CYCLES.
  - `btn_level` rises and `press_pulse` is high in the cycle following edge E(N+2). The latency is N+2 cycles.
- **Release latency:** symmetric, N+2 cycles from the first edge sampling `btn_raw`=0 to the cycle in which `btn_level` falls and `release_pulse` is high.
- **Glitch rejection:** any excursion of `s` shorter than N cycles produces no output change.
- **Bounce restart:** each bounce restarts the count from the next qualifying edge.
- **Minimum N:** with DEBOUNCE_CYCLES=1, PRESS_WAIT lasts exactly one cycle.
- **Pulse width:** each pulse is exactly one `clk` cycle.

## Test plan
Bench uses DEBOUNCE_CYCLES=4, CNT_W=3.
- **Reset:** hold `rst`=1 for 3 cycles with `btn_raw`=1 → `btn_level`=0, `press_pulse`=0, `release_pulse`=0 throughout.
- **Clean press:** `btn_raw` 0→1, held 20 cycles → `press_pulse`=1 for exactly one cycle, 6 cycles after the first edge sampling 1. `btn_level`=1 from that cycle on. No `release_pulse`.
- **Short glitch:** `btn_raw` high for 3 cycles, then low → `btn_level` stays 0; `press_pulse` never asserts.
- **Press bounce:** `btn_raw` = 1,0,1,0,1 on successive cycles, then held 1 → exactly one `press_pulse`, 6 cycles after the final 0→1 sample.
- **Release with bounce:** from PRESSED, `btn_raw` = 0,1,0 on successive cycles, then held 0 → `btn_level` stays 1 through the bounce. One `release_pulse` and the `btn_level` fall occur 6 cycles after the final 1→0 sample.
- **Reset mid-press:** in PRESSED with `btn_raw` held 1, assert `rst` for 2 cycles → outputs 0 during reset. After release, `press_pulse` fires once, 6 cycles after the first post-reset edge.
